axis_1553_decoder: RTL and testbench



---
 rtl/axis_1553_pkg.sv | 43 ++++
 rtl/axis_1553_sampler.sv | 74 +++++++
 rtl/axis_1553_decoder.sv | 185 ++++++++++++++++++
 tb/tb_axis_1553_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/axis_1553_pkg.sv
// +----------------------------------------------------------------------------
// | Module  : axis_1553_pkg
// | Brief   : Shared constants and types for the MIL-STD-1553 AXIS receive decoder.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package axis_1553_pkg;

    localparam logic [1:0] SYNC_CMD  = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    localparam int TUSER_SYNC_HI = 7;
    localparam int TUSER_SYNC_LO = 6;
    localparam int TUSER_OVERRUN = 2;
    localparam int TUSER_PERR    = 1;

    localparam int BITS_PER_WORD     = 16;
    localparam int SAMPLES_PER_FRAME = 40;

    localparam int c_SYNC_SAMPLES = 6;
    localparam int c_DATA_SAMPLES = SAMPLES_PER_FRAME - c_SYNC_SAMPLES;

    // Sync is three half-bits at one level then three at the other.
    localparam logic [5:0] c_SYNC_PAT_CMD  = 6'b111000;
    localparam logic [5:0] c_SYNC_PAT_DATA = 6'b000111;

    localparam logic [0:0] c_ST_HUNT = 1'b0;
    localparam logic [0:0] c_ST_DATA = 1'b1;

    typedef enum logic [0:0] {
        ST_HUNT = c_ST_HUNT,
        ST_DATA = c_ST_DATA
    } state_t;

    // Odd parity over data plus parity bit: the XOR of all 17 bits must be 1.
    function automatic logic parity_error(input logic [BITS_PER_WORD:0] word);
        return ~(^word);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_1553_sampler.sv
// +----------------------------------------------------------------------------
// | Module  : axis_1553_sampler
// | Brief   : Synchronises the bus pair and strobes one sample per half-bit,
// |           re-centred on every transition of the positive line.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module axis_1553_sampler #(
    parameter int CLOCK_SPEED = 100000000,
    parameter int SAMPLE_RATE = 2000000
) (
    input  logic       aclk,
    input  logic       arstn,
    input  logic [1:0] i_diff,
    output logic       o_sample_stb,
    output logic [1:0] o_sample_diff
);

    localparam int c_DIV   = CLOCK_SPEED / SAMPLE_RATE;
    localparam int c_CNT_W = $clog2(c_DIV + 1);

    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(c_DIV / 2);
    localparam logic [c_CNT_W-1:0] c_PERIOD = c_CNT_W'(c_DIV - 1);

    if (SAMPLE_RATE != 2000000) begin : g_bad_rate
        $error("axis_1553_sampler: SAMPLE_RATE must be 2000000");
    end

    if ((CLOCK_SPEED % SAMPLE_RATE) != 0 || c_DIV < 4) begin : g_bad_div
        $error("axis_1553_sampler: CLOCK_SPEED must be an integer multiple (>=4) of SAMPLE_RATE");
    end

    logic [1:0]         r_meta;
    logic [1:0]         r_sync;
    logic               r_prev_p;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stb;
    logic [1:0]         r_sample;
    logic               w_edge;

    assign w_edge = r_sync[1] ^ r_prev_p;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_meta   <= 2'b00;
            r_sync   <= 2'b00;
            r_prev_p <= 1'b0;
            r_cnt    <= '0;
            r_stb    <= 1'b0;
            r_sample <= 2'b00;
        end else begin
            r_meta   <= i_diff;
            r_sync   <= r_meta;
            r_prev_p <= r_sync[1];
            r_stb    <= 1'b0;
            if (w_edge) begin
                r_cnt <= c_RELOAD;
            end else if (r_cnt == '0) begin
                r_cnt    <= c_PERIOD;
                r_stb    <= 1'b1;
                r_sample <= r_sync;
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    assign o_sample_stb  = r_stb;
    assign o_sample_diff = r_sample;

endmodule

`default_nettype wire

// File: rtl/axis_1553_decoder.sv
// +----------------------------------------------------------------------------
// | Module  : axis_1553_decoder
// | Brief   : MIL-STD-1553 Manchester-II receive decoder with AXI-Stream output.
// |           Option macro AXIS_1553_DECODER_PARITY_DROP_EN: drop words with
// |           parity errors instead of flagging them in tuser.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module axis_1553_decoder
    import axis_1553_pkg::*;
#(
    parameter int CLOCK_SPEED = 100000000,
    parameter int SAMPLE_RATE = 2000000
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [1:0]  diff,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tuser,
    input  logic        m_axis_tready
);

    logic       w_stb;
    logic [1:0] w_samp;
    logic       w_bit;
    logic       w_ok;

    axis_1553_sampler #(
        .CLOCK_SPEED (CLOCK_SPEED),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_sampler (
        .aclk          (aclk),
        .arstn         (arstn),
        .i_diff        (diff),
        .o_sample_stb  (w_stb),
        .o_sample_diff (w_samp)
    );

    assign w_bit = w_samp[1];
    assign w_ok  = w_samp[1] ^ w_samp[0];

    state_t                 r_state,     w_state_nxt;
    logic [5:0]             r_win,       w_win_nxt;
    logic [2:0]             r_win_cnt,   w_win_cnt_nxt;
    logic [1:0]             r_sync_type, w_sync_nxt;
    logic [5:0]             r_idx,       w_idx_nxt;
    logic                   r_first,     w_first_nxt;
    logic [BITS_PER_WORD:0] r_shift,     w_shift_nxt;
    logic                   w_word_done;

    logic [5:0]             w_win_shift;
    logic [BITS_PER_WORD:0] w_pair_shift;

    assign w_win_shift  = {r_win[4:0], w_bit};
    assign w_pair_shift = {r_shift[BITS_PER_WORD-1:0], r_first};

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= ST_HUNT;
            r_win       <= '0;
            r_win_cnt   <= '0;
            r_sync_type <= 2'b00;
            r_idx       <= '0;
            r_first     <= 1'b0;
            r_shift     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win       <= w_win_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_sync_type <= w_sync_nxt;
            r_idx       <= w_idx_nxt;
            r_first     <= w_first_nxt;
            r_shift     <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_win_nxt     = r_win;
        w_win_cnt_nxt = r_win_cnt;
        w_sync_nxt    = r_sync_type;
        w_idx_nxt     = r_idx;
        w_first_nxt   = r_first;
        w_shift_nxt   = r_shift;
        w_word_done   = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (w_stb) begin
                    if (!w_ok) begin
                        w_win_nxt     = '0;
                        w_win_cnt_nxt = '0;
                    end else begin
                        w_win_nxt = w_win_shift;
                        if (r_win_cnt < 3'd6) begin
                            w_win_cnt_nxt = r_win_cnt + 3'd1;
                        end
                        // A match needs six consecutive valid samples in the window.
                        if (r_win_cnt >= 3'd5) begin
                            if (w_win_shift == c_SYNC_PAT_CMD || w_win_shift == c_SYNC_PAT_DATA) begin
                                w_sync_nxt    = (w_win_shift == c_SYNC_PAT_CMD) ? SYNC_CMD : SYNC_DATA;
                                w_state_nxt   = ST_DATA;
                                w_idx_nxt     = '0;
                                w_shift_nxt   = '0;
                                w_win_nxt     = '0;
                                w_win_cnt_nxt = '0;
                            end
                        end
                    end
                end
            end
            ST_DATA: begin
                if (w_stb) begin
                    if (!w_ok) begin
                        w_state_nxt = ST_HUNT;
                    end else if (!r_idx[0]) begin
                        w_first_nxt = w_bit;
                        w_idx_nxt   = r_idx + 6'd1;
                    end else if (r_first == w_bit) begin
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_shift_nxt = w_pair_shift;
                        if (r_idx == 6'(c_DATA_SAMPLES - 1)) begin
                            w_word_done = 1'b1;
                            w_state_nxt = ST_HUNT;
                        end else begin
                            w_idx_nxt = r_idx + 6'd1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    logic [BITS_PER_WORD-1:0] r_tdata;
    logic                     r_tvalid;
    logic [7:0]               r_tuser;
    logic [7:0]               w_tuser;
    logic                     w_perr;
    logic                     w_perr_flag;
    logic                     w_deliver;

    assign w_perr = parity_error(w_pair_shift);

`ifdef AXIS_1553_DECODER_PARITY_DROP_EN
    assign w_deliver   = w_word_done && !w_perr;
    assign w_perr_flag = 1'b0;
`else
    assign w_deliver   = w_word_done;
    assign w_perr_flag = w_perr;
`endif

    always_comb begin
        w_tuser                              = '0;
        w_tuser[TUSER_SYNC_HI:TUSER_SYNC_LO] = r_sync_type;
        w_tuser[TUSER_OVERRUN]               = r_tvalid && !m_axis_tready;
        w_tuser[TUSER_PERR]                  = w_perr_flag;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= '0;
        end else if (w_deliver) begin
            r_tdata  <= w_pair_shift[BITS_PER_WORD:1];
            r_tvalid <= 1'b1;
            r_tuser  <= w_tuser;
        end else if (r_tvalid && m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;

endmodule

`default_nettype wire

// File: tb/tb_axis_1553_decoder.sv
// +----------------------------------------------------------------------------
// | Module  : tb_axis_1553_decoder
// | Brief   : Directed bench for axis_1553_decoder with hand-computed words.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_axis_1553_decoder;

    localparam int DIV = 50;
    localparam logic [1:0] CMD  = 2'b01;
    localparam logic [1:0] DATA = 2'b10;

    logic        tb_data_clk = 1'b0;
    logic        arstn;
    logic [1:0]  diff;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tready;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          base;
    logic [15:0] cap_data = '0;
    logic [7:0]  cap_user = '0;

    always #5 tb_data_clk = ~tb_data_clk;

    axis_1553_decoder u_dut (
        .aclk          (tb_data_clk),
        .arstn         (arstn),
        .diff          (diff),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

    always @(negedge tb_data_clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            xfer_cnt = xfer_cnt + 1;
            cap_data = m_axis_tdata;
            cap_user = m_axis_tuser;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic half(input logic b);
        diff = {b, ~b};
        repeat (DIV) @(posedge tb_data_clk);
        #1;
    endtask

    task automatic idle(input logic lvl, input int n);
        diff = {lvl, lvl};
        repeat (n) @(posedge tb_data_clk);
        #1;
    endtask

    // n_bits of the 17-bit word are sent; bit number bad_bit is sent as pair 11.
    task automatic send_frame(input logic [1:0] sync, input logic [15:0] data, input logic par,
                              input int n_bits, input int bad_bit);
        logic [16:0] w;
        logic        lead;
        logic        b;
        w    = {data, par};
        lead = (sync == CMD);
        for (int i = 0; i < 3; i++) half(lead);
        for (int i = 0; i < 3; i++) half(~lead);
        for (int i = 0; i < n_bits; i++) begin
            b = w[16-i];
            if (i == bad_bit) begin
                half(1'b1);
                half(1'b1);
            end else begin
                half(b);
                half(~b);
            end
        end
    endtask

    task automatic word(input logic [1:0] sync, input logic [15:0] data, input logic par);
        idle(sync == DATA, 100);
        send_frame(sync, data, par, 17, -1);
        idle(1'b0, 200);
    endtask

    initial begin
        arstn         = 1'b0;
        diff          = 2'b00;
        m_axis_tready = 1'b1;
        repeat (4) @(negedge tb_data_clk);
        check_val("rst_tdata",  32'(m_axis_tdata),  32'h0);
        check_val("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check_val("rst_tuser",  32'(m_axis_tuser),  32'h0);
        @(posedge tb_data_clk);
        #1;
        arstn = 1'b1;

        base = xfer_cnt;
        word(CMD, 16'hFFFF, 1'b1);
        check_val("ffff_count", 32'(xfer_cnt - base), 32'd1);
        check_val("ffff_data",  32'(cap_data), 32'h0000FFFF);
        check_val("ffff_user",  32'(cap_user), 32'h40);

        base = xfer_cnt;
        word(DATA, 16'h0000, 1'b1);
        check_val("zero_count", 32'(xfer_cnt - base), 32'd1);
        check_val("zero_data",  32'(cap_data), 32'h0);
        check_val("zero_user",  32'(cap_user), 32'h80);

        // 0x1234 has five ones, so parity bit 1 is the wrong one.
        base = xfer_cnt;
        word(CMD, 16'h1234, 1'b1);
`ifdef AXIS_1553_DECODER_PARITY_DROP_EN
        check_val("perr_count", 32'(xfer_cnt - base), 32'd0);
`else
        check_val("perr_count", 32'(xfer_cnt - base), 32'd1);
        check_val("perr_data",  32'(cap_data), 32'h00001234);
        check_val("perr_user",  32'(cap_user), 32'h42);
`endif

        m_axis_tready = 1'b0;
        idle(1'b0, 100);
        send_frame(CMD, 16'h0001, 1'b0, 17, -1);
        send_frame(DATA, 16'h0002, 1'b0, 17, -1);
        idle(1'b0, 200);
        check_val("ovr_tvalid", 32'(m_axis_tvalid), 32'h1);
        check_val("ovr_data",   32'(m_axis_tdata),  32'h00000002);
        check_val("ovr_user",   32'(m_axis_tuser),  32'h84);
        m_axis_tready = 1'b1;
        @(negedge tb_data_clk);
        @(negedge tb_data_clk);
        check_val("ovr_drop",   32'(m_axis_tvalid), 32'h0);

        base = xfer_cnt;
        idle(1'b0, 100);
        send_frame(CMD, 16'hFFFF, 1'b1, 6, 5);
        idle(1'b0, 200);
        check_val("ferr_count", 32'(xfer_cnt - base), 32'd0);
        base = xfer_cnt;
        word(CMD, 16'hA5A5, 1'b1);
        check_val("a5_count", 32'(xfer_cnt - base), 32'd1);
        check_val("a5_data",  32'(cap_data), 32'h0000A5A5);
        check_val("a5_user",  32'(cap_user), 32'h40);

        idle(1'b0, 100);
        send_frame(CMD, 16'h5A3C, 1'b1, 8, -1);
        diff = 2'b10;
        repeat (20) @(posedge tb_data_clk);
        #1;
        arstn = 1'b0;
        repeat (3) @(negedge tb_data_clk);
        check_val("mrst_tdata",  32'(m_axis_tdata),  32'h0);
        check_val("mrst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check_val("mrst_tuser",  32'(m_axis_tuser),  32'h0);
        @(posedge tb_data_clk);
        #1;
        arstn = 1'b1;
        idle(1'b0, 200);
        check_val("mrst_quiet", 32'(m_axis_tvalid), 32'h0);
        base = xfer_cnt;
        word(DATA, 16'h5A3C, 1'b1);
        check_val("post_count", 32'(xfer_cnt - base), 32'd1);
        check_val("post_data",  32'(cap_data), 32'h00005A3C);
        check_val("post_user",  32'(cap_user), 32'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
